spectrum_peak_collector: RTL and testbench

Consumer side of the FFT magnitude readout: drives the `index` bus that the magnitude engine samples, and captures each `magnitude`/`magnitude_ready` result. For each completed 512-bin frame it keeps the peak bin of every frequency band and emits one record per band on a valid/ready stream toward the fingerprint hasher. It sits between the FFT magnitude engine and the constellation/hash logic.

---
 rtl/spectrum_band_pkg.sv | 31 +++
 rtl/spectrum_peak_collector_if.sv | 30 +++
 rtl/band_decode.sv | 24 ++
 rtl/spectrum_peak_collector.sv | 208 ++++++++++++++++++++
 tb/tb_spectrum_peak_collector.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spectrum_band_pkg.sv
// Shared types and constants for the spectrum peak collector.
//   NBANDS/BIN_W/BAND_W/FCNT_W : structural widths
//   BAND_LO/BAND_HI            : inclusive bin range of each frequency band
//   rec_hdr_t                  : record header (band, peak bin, last flag)
//   col_state_e/em_state_e     : collector and emitter FSM encodings
package spectrum_band_pkg;

  localparam int unsigned NBANDS = 6;
  localparam int unsigned BIN_W  = 9;
  localparam int unsigned BAND_W = 3;
  localparam int unsigned FCNT_W = 16;

  typedef logic [BIN_W-1:0]  bin_t;
  typedef logic [BAND_W-1:0] band_t;

  // Bin 0 (DC) belongs to no band.
  localparam bin_t BAND_LO [NBANDS] = '{9'd1,  9'd11, 9'd21, 9'd41, 9'd81,  9'd161};
  localparam bin_t BAND_HI [NBANDS] = '{9'd10, 9'd20, 9'd40, 9'd80, 9'd160, 9'd511};

  localparam band_t LAST_BAND = band_t'(NBANDS - 1);

  typedef struct packed {
    band_t band;
    bin_t  bin;
    logic  last;
  } rec_hdr_t;

  typedef enum logic {COLLECT, SNAP} col_state_e;
  typedef enum logic {IDLE, EMIT}    em_state_e;

endpackage

// File: rtl/spectrum_peak_collector_if.sv
// Bus bundle of the peak collector.
//   magnitude_ready/magnitude/index : FFT magnitude engine readout
//   rec_valid/rec_ready/rec_*       : per-band peak record stream
//   overrun/frame_count             : status
// master = collector side, slave = engine/downstream side.
interface spectrum_peak_collector_if #(
  parameter int unsigned MAG_W = 16
);
  logic                      magnitude_ready;
  logic [MAG_W-1:0]          magnitude;
  spectrum_band_pkg::bin_t   index;
  logic                      rec_valid;
  logic                      rec_ready;
  spectrum_band_pkg::band_t  rec_band;
  spectrum_band_pkg::bin_t   rec_bin;
  logic [MAG_W-1:0]          rec_mag;
  logic                      rec_last;
  logic                      overrun;
  logic [15:0]               frame_count;

  modport master (
    input  magnitude_ready, magnitude, rec_ready,
    output index, rec_valid, rec_band, rec_bin, rec_mag, rec_last, overrun, frame_count
  );

  modport slave (
    output magnitude_ready, magnitude, rec_ready,
    input  index, rec_valid, rec_band, rec_bin, rec_mag, rec_last, overrun, frame_count
  );
endinterface

// File: rtl/band_decode.sv
// Combinational bin -> band lookup against the package band table.
//   bin     : bin number 0..511
//   band    : band id of bin (0 when not in any band)
//   in_band : bin falls inside one of the bands (false for DC)
module band_decode
  import spectrum_band_pkg::*;
(
  input  bin_t  bin,
  output band_t band,
  output logic  in_band
);

  always_comb begin
    band    = '0;
    in_band = 1'b0;
    for (int unsigned b = 0; b < NBANDS; b++) begin
      if (bin >= BAND_LO[b] && bin <= BAND_HI[b]) begin
        band    = band_t'(b);
        in_band = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spectrum_peak_collector.sv
// Captures FFT magnitudes bin by bin, tracks the peak bin per band and
// streams one record per band per completed frame.
//   clk, reset : clock, synchronous active-high reset
//   bus        : master side of spectrum_peak_collector_if
//                (engine readout in, record stream + status out)
// index is a combinational look-ahead: the engine samples it in the strobe
// cycle, so it already shows the bin after the one being delivered.
module spectrum_peak_collector
  import spectrum_band_pkg::*;
#(
  parameter int unsigned NBINS = 512,
  parameter int unsigned MAG_W = 16
) (
  input logic                        clk,
  input logic                        reset,
  spectrum_peak_collector_if.master  bus
);

  localparam bin_t LAST_BIN = bin_t'(NBINS - 1);

  typedef logic [MAG_W-1:0] mag_t;

  col_state_e col_state_q, col_state_d;
  em_state_e  em_state_q,  em_state_d;

  bin_t  bin_cnt_q, bin_cnt_d;
  logic  end_pend_q, end_pend_d;

  mag_t  best_mag_q   [NBANDS];
  mag_t  best_mag_d   [NBANDS];
  bin_t  best_bin_q   [NBANDS];
  bin_t  best_bin_d   [NBANDS];
  mag_t  shadow_mag_q [NBANDS];
  mag_t  shadow_mag_d [NBANDS];
  bin_t  shadow_bin_q [NBANDS];
  bin_t  shadow_bin_d [NBANDS];

  band_t    em_band_q, em_band_d;
  logic     rec_valid_q, rec_valid_d;
  rec_hdr_t rec_hdr_q, rec_hdr_d;
  mag_t     rec_mag_q, rec_mag_d;
  logic     overrun_q, overrun_d;
  logic [FCNT_W-1:0] frame_count_q, frame_count_d;

  band_t cur_band;
  logic  cur_in_band;
  bin_t  index_c;
  band_t nxt_band_c;
  logic  frame_end_c;
  logic  handshake_c;
  logic  em_free_c;
  logic  snap_c;

  band_decode u_band_decode (
    .bin     (bin_cnt_q),
    .band    (cur_band),
    .in_band (cur_in_band)
  );

  // Look-ahead bin request; wraps to 0 on the final bin of a frame.
  assign frame_end_c = bus.magnitude_ready && (bin_cnt_q == LAST_BIN);
  assign index_c     = frame_end_c ? '0 : bin_cnt_q + bin_t'(bus.magnitude_ready);

  assign snap_c      = (col_state_q == SNAP);
  assign handshake_c = rec_valid_q && bus.rec_ready;
  // A final handshake in the snap cycle frees the emitter just in time.
  assign em_free_c   = (em_state_q == IDLE) || (handshake_c && rec_hdr_q.last);
  assign nxt_band_c  = em_band_q + band_t'(1);

  // Bin counter and running per-band maxima; strict '>' keeps the lowest bin on ties.
  always_comb begin
    bin_cnt_d  = bin_cnt_q;
    end_pend_d = end_pend_q;
    best_mag_d = best_mag_q;
    best_bin_d = best_bin_q;
    if (bus.magnitude_ready) begin
      bin_cnt_d = index_c;
      if (frame_end_c) begin
        end_pend_d = 1'b1;
      end
      for (int unsigned b = 0; b < NBANDS; b++) begin
        if (cur_in_band && cur_band == band_t'(b) && bus.magnitude > best_mag_q[b]) begin
          best_mag_d[b] = bus.magnitude;
          best_bin_d[b] = bin_cnt_q;
        end
      end
    end
    if (snap_c) begin
      end_pend_d = 1'b0;
      for (int unsigned b = 0; b < NBANDS; b++) begin
        best_mag_d[b] = '0;
        best_bin_d[b] = BAND_LO[b];
      end
    end
  end

  // Collector FSM: one SNAP cycle per completed frame.
  always_comb begin
    col_state_d = col_state_q;
    unique case (col_state_q)
      COLLECT: if (end_pend_q) col_state_d = SNAP;
      SNAP:    col_state_d = COLLECT;
      default: col_state_d = COLLECT;
    endcase
  end

  // Emitter FSM plus snapshot hand-off; record fields are registered.
  always_comb begin
    em_state_d    = em_state_q;
    em_band_d     = em_band_q;
    rec_valid_d   = rec_valid_q;
    rec_hdr_d     = rec_hdr_q;
    rec_mag_d     = rec_mag_q;
    shadow_mag_d  = shadow_mag_q;
    shadow_bin_d  = shadow_bin_q;
    overrun_d     = overrun_q;
    frame_count_d = frame_count_q;

    unique case (em_state_q)
      IDLE: begin
      end
      EMIT: begin
        if (handshake_c) begin
          if (rec_hdr_q.last) begin
            em_state_d  = IDLE;
            rec_valid_d = 1'b0;
          end else begin
            em_band_d      = nxt_band_c;
            rec_hdr_d.band = nxt_band_c;
            rec_hdr_d.last = (nxt_band_c == LAST_BAND);
            for (int unsigned b = 0; b < NBANDS; b++) begin
              if (band_t'(b) == nxt_band_c) begin
                rec_hdr_d.bin = shadow_bin_q[b];
                rec_mag_d     = shadow_mag_q[b];
              end
            end
          end
        end
      end
      default: em_state_d = IDLE;
    endcase

    // Snapshot overrides the advance above: band 0 is presented straight from the bests.
    if (snap_c) begin
      frame_count_d = frame_count_q + FCNT_W'(1);
      if (em_free_c) begin
        shadow_mag_d   = best_mag_q;
        shadow_bin_d   = best_bin_q;
        em_state_d     = EMIT;
        em_band_d      = '0;
        rec_valid_d    = 1'b1;
        rec_hdr_d.band = '0;
        rec_hdr_d.bin  = best_bin_q[0];
        rec_hdr_d.last = 1'b0;
        rec_mag_d      = best_mag_q[0];
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_state_q   <= COLLECT;
      em_state_q    <= IDLE;
      bin_cnt_q     <= '0;
      end_pend_q    <= 1'b0;
      em_band_q     <= '0;
      rec_valid_q   <= 1'b0;
      rec_hdr_q     <= '0;
      rec_mag_q     <= '0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
      for (int unsigned b = 0; b < NBANDS; b++) begin
        best_mag_q[b]   <= '0;
        best_bin_q[b]   <= BAND_LO[b];
        shadow_mag_q[b] <= '0;
        shadow_bin_q[b] <= BAND_LO[b];
      end
    end else begin
      col_state_q   <= col_state_d;
      em_state_q    <= em_state_d;
      bin_cnt_q     <= bin_cnt_d;
      end_pend_q    <= end_pend_d;
      em_band_q     <= em_band_d;
      rec_valid_q   <= rec_valid_d;
      rec_hdr_q     <= rec_hdr_d;
      rec_mag_q     <= rec_mag_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
      best_mag_q    <= best_mag_d;
      best_bin_q    <= best_bin_d;
      shadow_mag_q  <= shadow_mag_d;
      shadow_bin_q  <= shadow_bin_d;
    end
  end

  assign bus.index       = index_c;
  assign bus.rec_valid   = rec_valid_q;
  assign bus.rec_band    = rec_hdr_q.band;
  assign bus.rec_bin     = rec_hdr_q.bin;
  assign bus.rec_mag     = rec_mag_q;
  assign bus.rec_last    = rec_hdr_q.last;
  assign bus.overrun     = overrun_q;
  assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_spectrum_peak_collector.sv
// Self-checking bench for spectrum_peak_collector: random-gap magnitude
// frames, a per-band max reference model and a record scoreboard.
module tb_spectrum_peak_collector;

  localparam int unsigned NB = 512;
  localparam int unsigned MW = 16;
  localparam int BLO [6] = '{1, 11, 21, 41, 81, 161};
  localparam int BHI [6] = '{10, 20, 40, 80, 160, 511};

  typedef struct {
    int band;
    int bin;
    int mag;
    bit last;
  } exp_rec_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  spectrum_peak_collector_if #(.MAG_W(MW)) bus ();

  spectrum_peak_collector #(.NBINS(NB), .MAG_W(MW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int       n_checks = 0;
  int       n_pass   = 0;
  exp_rec_t exp_q[$];
  int       frame_mag [NB];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, want, $time);
  endtask

  // Reference: per band, the maximum magnitude, lowest bin on ties, low edge when all zero.
  task automatic push_expected();
    for (int b = 0; b < 6; b++) begin
      exp_rec_t r;
      r.band = b;
      r.bin  = BLO[b];
      r.mag  = 0;
      r.last = (b == 5);
      for (int i = BLO[b]; i <= BHI[b]; i++) begin
        if (frame_mag[i] > r.mag) begin
          r.mag = frame_mag[i];
          r.bin = i;
        end
      end
      exp_q.push_back(r);
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < int'(NB); i++) frame_mag[i] = i;
  endtask

  task automatic fill_random(input int maxv);
    for (int i = 0; i < int'(NB); i++) frame_mag[i] = int'($urandom_range(0, maxv));
  endtask

  task automatic fill_tie();
    for (int i = 0; i < int'(NB); i++) frame_mag[i] = 0;
    frame_mag[3] = 'h100;
    frame_mag[7] = 'h100;
  endtask

  // Sends bins 0..nbins-1 with 2-3 idle cycles before each strobe; the last strobe stays up.
  task automatic send_frame(input int nbins);
    for (int i = 0; i < nbins; i++) begin
      int gap;
      gap = int'($urandom_range(2, 3));
      repeat (gap) begin
        @(negedge clk);
        bus.magnitude_ready = 1'b0;
        #1;
        check("index_idle", 32'(bus.index), 32'(i));
      end
      @(negedge clk);
      bus.magnitude_ready = 1'b1;
      bus.magnitude       = MW'(frame_mag[i]);
      #1;
      check("index_strobe", 32'(bus.index), 32'((i + 1) % int'(NB)));
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.magnitude_ready = 1'b0;
    end
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      bus.magnitude_ready = 1'b0;
      #1;
      if (bus.rec_valid) break;
      k++;
    end
    check(tag, 32'(bus.rec_valid), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clk);
      bus.magnitude_ready = 1'b0;
      k++;
    end
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    cycles(3);
    #1;
    check({tag, "_idle"}, 32'(bus.rec_valid), 32'd0);
  endtask

  task automatic check_status(input string tag, input int fc, input bit ov);
    check({tag, "_fc"}, 32'(bus.frame_count), 32'(fc));
    check({tag, "_ovr"}, 32'(bus.overrun), 32'(ov));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.magnitude_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_index"}, 32'(bus.index), 32'd0);
    check({tag, "_valid"}, 32'(bus.rec_valid), 32'd0);
    check({tag, "_band"}, 32'(bus.rec_band), 32'd0);
    check({tag, "_bin"}, 32'(bus.rec_bin), 32'd0);
    check({tag, "_mag"}, 32'(bus.rec_mag), 32'd0);
    check({tag, "_last"}, 32'(bus.rec_last), 32'd0);
    check_status(tag, 0, 1'b0);
  endtask

  // Scoreboard: every accepted record must match the head of the expected queue.
  initial begin
    exp_rec_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset === 1'b0 && bus.rec_valid && bus.rec_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rec", 32'(bus.rec_band), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("rec_band", 32'(bus.rec_band), 32'(e.band));
          check("rec_bin", 32'(bus.rec_bin), 32'(e.bin));
          check("rec_mag", 32'(bus.rec_mag), 32'(e.mag));
          check("rec_last", 32'(bus.rec_last), 32'(e.last));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    reset               = 1'b1;
    bus.magnitude_ready = 1'b0;
    bus.magnitude       = '0;
    bus.rec_ready       = 1'b1;
    apply_reset();
    check_reset_outputs("rst");

    // Ramp frame: exact latency and six back-to-back records.
    fill_ramp();
    push_expected();
    send_frame(NB);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      bus.magnitude_ready = 1'b0;
      #1;
      check("lat_valid", 32'(bus.rec_valid), (k >= 3 && k <= 8) ? 32'd1 : 32'd0);
      if (k >= 3 && k <= 8) check("lat_band", 32'(bus.rec_band), 32'(k - 3));
    end
    wait_drain("ramp");
    check_status("ramp", 1, 1'b0);

    // Tie in band 0 and all-zero bands.
    fill_tie();
    push_expected();
    send_frame(NB);
    wait_drain("tie");
    check_status("tie", 2, 1'b0);

    // Random frames, one with a narrow range to force many ties.
    fill_random(15);
    push_expected();
    send_frame(NB);
    wait_drain("rnd_narrow");
    fill_random(65535);
    push_expected();
    send_frame(NB);
    wait_drain("rnd_wide");
    check_status("rnd", 4, 1'b0);

    // Backpressure: record held stable for 10 cycles.
    fill_random(65535);
    push_expected();
    bus.rec_ready = 1'b0;
    send_frame(NB);
    wait_valid("bp_wait");
    repeat (10) begin
      @(negedge clk);
      #1;
      check("bp_valid", 32'(bus.rec_valid), 32'd1);
      check("bp_band", 32'(bus.rec_band), 32'(exp_q[0].band));
      check("bp_bin", 32'(bus.rec_bin), 32'(exp_q[0].bin));
      check("bp_mag", 32'(bus.rec_mag), 32'(exp_q[0].mag));
    end
    @(negedge clk);
    bus.rec_ready = 1'b1;
    wait_drain("bp");
    check_status("bp", 5, 1'b0);

    // Overrun: second frame dropped while the first is stalled.
    fill_random(65535);
    push_expected();
    bus.rec_ready = 1'b0;
    send_frame(NB);
    wait_valid("ov_wait");
    fill_random(65535);
    send_frame(NB);
    cycles(4);
    #1;
    check_status("ov", 7, 1'b1);
    @(negedge clk);
    bus.rec_ready = 1'b1;
    wait_drain("ov");
    check_status("ov_after", 7, 1'b1);

    // Reset at bin 200 discards the partial frame.
    fill_ramp();
    send_frame(200);
    apply_reset();
    check_reset_outputs("midrst");
    push_expected();
    send_frame(NB);
    wait_drain("midrst_ramp");
    check_status("midrst_ramp", 1, 1'b0);

    // Final handshake of frame A lands in frame B's snap cycle.
    fill_random(255);
    push_expected();
    bus.rec_ready = 1'b0;
    send_frame(NB);
    wait_valid("co_wait");
    repeat (5) begin
      @(negedge clk);
      bus.rec_ready = 1'b1;
    end
    @(negedge clk);
    bus.rec_ready = 1'b0;
    #1;
    check("co_band5", 32'(bus.rec_band), 32'd5);
    fill_random(65535);
    push_expected();
    send_frame(NB);
    @(negedge clk);
    bus.magnitude_ready = 1'b0;
    #1;
    check("co_pre_valid", 32'(bus.rec_valid), 32'd1);
    check("co_pre_band", 32'(bus.rec_band), 32'd5);
    @(negedge clk);
    bus.rec_ready = 1'b1;
    #1;
    check("co_snap_last", 32'(bus.rec_last), 32'd1);
    @(negedge clk);
    #1;
    check("co_nogap_valid", 32'(bus.rec_valid), 32'd1);
    check("co_nogap_band", 32'(bus.rec_band), 32'd0);
    wait_drain("co");
    check_status("co", 3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
